writeback: RTL

Write-back arbiter and register scoreboard sitting directly upstream of the integer register file. It merges single-cycle execute results with results from a long-latency unit (load/mul/div) into the register file's single write port. It tracks which architectural registers have a long-latency write outstanding so decode can stall on RAW/WAW hazards. It also drives a starvation-avoidance stall to execute.

---
 rtl/writeback_pkg.sv | 39 +++
 rtl/writeback_scoreboard.sv | 44 ++++
 rtl/writeback.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/writeback_pkg.sv
// Shared types and constants for the write-back arbiter and register scoreboard.
package writeback_pkg;

   localparam int XLEN    = 32;
   localparam int NREG    = 32;
   localparam int AW      = $clog2(NREG);
   localparam int AGE_MAX = 2;

   typedef struct packed {
      logic            wren;
      logic [AW-1:0]   waddr;
      logic [XLEN-1:0] wdata;
   } register_write_in_type;

   typedef struct packed {
      logic            iss_valid;
      logic [AW-1:0]   iss_waddr;
      logic            chk_rden1;
      logic [AW-1:0]   chk_raddr1;
      logic            chk_rden2;
      logic [AW-1:0]   chk_raddr2;
      logic            chk_wren;
      logic [AW-1:0]   chk_waddr;
      logic            ex_valid;
      logic [AW-1:0]   ex_waddr;
      logic [XLEN-1:0] ex_wdata;
      logic            lg_valid;
      logic [AW-1:0]   lg_waddr;
      logic [XLEN-1:0] lg_wdata;
   } writeback_in_type;

   typedef struct packed {
      logic                  hazard;
      logic                  ex_stall;
      logic                  lg_ready;
      register_write_in_type register_win;
   } writeback_out_type;

endpackage

// File: rtl/writeback_scoreboard.sv
// Busy-register scoreboard: tracks outstanding long-latency writes and flags decode hazards.
module writeback_scoreboard
   import writeback_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_waddr,
   input  logic            clr_valid,
   input  logic [AW-1:0]   clr_waddr,
   input  logic            chk_rden1,
   input  logic [AW-1:0]   chk_raddr1,
   input  logic            chk_rden2,
   input  logic [AW-1:0]   chk_raddr2,
   input  logic            chk_wren,
   input  logic [AW-1:0]   chk_waddr,
   output logic [NREG-1:0] busy,
   output logic            hazard
);

   logic [NREG-1:0] busy_q, busy_d;

   // A re-issue to the register committing this edge must stay busy, so set is applied last.
   always_comb begin
      busy_d = busy_q;
      if (clr_valid) busy_d[clr_waddr] = 1'b0;
      if (iss_valid) busy_d[iss_waddr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy   = busy_q;
   assign hazard = (chk_rden1 & busy_q[chk_raddr1]) |
                   (chk_rden2 & busy_q[chk_raddr2]) |
                   (chk_wren  & busy_q[chk_waddr]);

endmodule

// File: rtl/writeback.sv
// Merges execute and long-latency results onto the register-file write port,
// with a one-entry long-result buffer and an age-based stall to prevent starvation.
module writeback
   import writeback_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  iss_valid,
   input  logic [AW-1:0]         iss_waddr,
   input  logic                  chk_rden1,
   input  logic [AW-1:0]         chk_raddr1,
   input  logic                  chk_rden2,
   input  logic [AW-1:0]         chk_raddr2,
   input  logic                  chk_wren,
   input  logic [AW-1:0]         chk_waddr,
   output logic                  hazard,
   input  logic                  ex_valid,
   input  logic [AW-1:0]         ex_waddr,
   input  logic [XLEN-1:0]       ex_wdata,
   output logic                  ex_stall,
   input  logic                  lg_valid,
   input  logic [AW-1:0]         lg_waddr,
   input  logic [XLEN-1:0]       lg_wdata,
   output logic                  lg_ready,
   output register_write_in_type register_win
);

   writeback_in_type      wb_in;
   writeback_out_type     wb_out;

   logic                  buf_valid_q, buf_valid_d;
   logic [AW-1:0]         buf_waddr_q, buf_waddr_d;
   logic [XLEN-1:0]       buf_wdata_q, buf_wdata_d;
   logic [1:0]            age_q, age_d;
   logic                  ex_stall_q, ex_stall_d;
   register_write_in_type win_q, win_d;
   logic                  win_long_q, win_long_d;
   logic                  capture, sel_buf;
   logic [AW-1:0]         sel_waddr;
   logic [XLEN-1:0]       sel_wdata;
   logic [NREG-1:0]       busy;
   logic                  sb_hazard;

   always_comb begin
      wb_in            = '0;
      wb_in.iss_valid  = iss_valid;
      wb_in.iss_waddr  = iss_waddr;
      wb_in.chk_rden1  = chk_rden1;
      wb_in.chk_raddr1 = chk_raddr1;
      wb_in.chk_rden2  = chk_rden2;
      wb_in.chk_raddr2 = chk_raddr2;
      wb_in.chk_wren   = chk_wren;
      wb_in.chk_waddr  = chk_waddr;
      wb_in.ex_valid   = ex_valid;
      wb_in.ex_waddr   = ex_waddr;
      wb_in.ex_wdata   = ex_wdata;
      wb_in.lg_valid   = lg_valid;
      wb_in.lg_waddr   = lg_waddr;
      wb_in.lg_wdata   = lg_wdata;
   end

   // Buffer is empty whenever capture is possible, so capture and drain never coincide.
   always_comb begin
      capture     = wb_in.lg_valid & ~buf_valid_q;
      sel_buf     = ~wb_in.ex_valid & buf_valid_q;
      sel_waddr   = wb_in.ex_valid ? wb_in.ex_waddr : buf_waddr_q;
      sel_wdata   = wb_in.ex_valid ? wb_in.ex_wdata : buf_wdata_q;

      buf_valid_d = buf_valid_q;
      buf_waddr_d = buf_waddr_q;
      buf_wdata_d = buf_wdata_q;
      if (capture) begin
         buf_valid_d = 1'b1;
         buf_waddr_d = wb_in.lg_waddr;
         buf_wdata_d = wb_in.lg_wdata;
      end else if (sel_buf) begin
         buf_valid_d = 1'b0;
      end

      age_d = '0;
      if (buf_valid_q && wb_in.ex_valid) begin
         age_d = (age_q == 2'b11) ? age_q : age_q + 2'd1;
      end
      ex_stall_d = buf_valid_q & wb_in.ex_valid & (age_q >= 2'(AGE_MAX - 1));

      win_d      = win_q;
      win_d.wren = (wb_in.ex_valid | buf_valid_q) & (sel_waddr != '0);
      if (win_d.wren) begin
         win_d.waddr = sel_waddr;
         win_d.wdata = sel_wdata;
      end
      win_long_d = sel_buf;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_valid_q <= 1'b0;
         buf_waddr_q <= '0;
         buf_wdata_q <= '0;
         age_q       <= '0;
         ex_stall_q  <= 1'b0;
         win_q       <= '0;
         win_long_q  <= 1'b0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_waddr_q <= buf_waddr_d;
         buf_wdata_q <= buf_wdata_d;
         age_q       <= age_d;
         ex_stall_q  <= ex_stall_d;
         win_q       <= win_d;
         win_long_q  <= win_long_d;
      end
   end

   writeback_scoreboard u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .iss_valid  (wb_in.iss_valid),
      .iss_waddr  (wb_in.iss_waddr),
      .clr_valid  (win_q.wren & win_long_q),
      .clr_waddr  (win_q.waddr),
      .chk_rden1  (wb_in.chk_rden1),
      .chk_raddr1 (wb_in.chk_raddr1),
      .chk_rden2  (wb_in.chk_rden2),
      .chk_raddr2 (wb_in.chk_raddr2),
      .chk_wren   (wb_in.chk_wren),
      .chk_waddr  (wb_in.chk_waddr),
      .busy       (busy),
      .hazard     (sb_hazard)
   );

   always_comb begin
      wb_out              = '0;
      wb_out.hazard       = sb_hazard;
      wb_out.ex_stall     = ex_stall_q;
      wb_out.lg_ready     = ~buf_valid_q;
      wb_out.register_win = win_q;
   end

   assign hazard       = wb_out.hazard;
   assign ex_stall     = wb_out.ex_stall;
   assign lg_ready     = wb_out.lg_ready;
   assign register_win = wb_out.register_win;

   // Upstream protocol violations; the datapath does not recover from these.
   a_ex_busy: assert property (@(posedge clk) disable iff (!rst)
      wb_in.ex_valid |-> !busy[wb_in.ex_waddr]);
   a_ex_stall: assert property (@(posedge clk) disable iff (!rst)
      wb_in.ex_valid |-> !ex_stall_q);
   a_lg_busy: assert property (@(posedge clk) disable iff (!rst)
      wb_in.lg_valid |-> (wb_in.lg_waddr == '0 || busy[wb_in.lg_waddr]));

endmodule
